// File: rtl/io_flag_unit.sv
`default_nettype none
// ============================================================================
// Module   : io_flag_unit
// Brief    : Device-side I/O flag, data-buffer and interrupt block. Holds one
//            input word (INPR) and one output word (OUTR), runs the
//            valid/ready handshakes with the external devices, owns the
//            FGI/FGO/IEN flags and raises a registered level interrupt.
// Revision : 1.0 - initial release
// ============================================================================
module io_flag_unit #(
    parameter int DATA_W = 16
) (
    input  logic              clk,
    input  logic              reset_n,
    // Controller strobes, one cycle each, level-sampled every cycle
    input  logic              rFI,
    input  logic              sFO,
    input  logic              rFO,
    input  logic              ION,
    input  logic              IOF,
    // CPU data path
    input  logic              out_wr,
    input  logic [DATA_W-1:0] out_data,
    output logic [DATA_W-1:0] in_data,
    // Input device handshake
    input  logic              dev_in_valid,
    input  logic [DATA_W-1:0] dev_in_data,
    output logic              dev_in_ready,
    // Output device handshake
    output logic              dev_out_valid,
    output logic [DATA_W-1:0] dev_out_data,
    input  logic              dev_out_ready,
    // Interrupt interface
    output logic              irq,
    input  logic              irq_ack,
    // Flags visible to the CPU
    output logic              FGI,
    output logic              FGO,
    output logic              IEN
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_SVC  = 2'd2
    } irq_state_t;

    logic [DATA_W-1:0] inpr_q, inpr_d;
    logic [DATA_W-1:0] outr_q, outr_d;
    logic              fgi_q, fgi_d;
    logic              fgo_q, fgo_d;
    logic              odone_q, odone_d;
    logic              ien_q, ien_d;
    logic              irq_q, irq_d;
    irq_state_t        state_q, state_d;

    logic in_xfer;
    logic out_done;
    logic ack_accept;
    logic src;

    // A word is only accepted while the buffer is empty, so a same-cycle rFI
    // can only coincide with a transfer when FGI is already 0.
    assign in_xfer    = dev_in_valid & ~fgi_q;
    assign out_done   = fgo_q & dev_out_ready;
    assign ack_accept = (state_q == ST_REQ) & irq_ack & ~IOF;
    assign src        = ien_q & (fgi_q | odone_q);

    // Input buffer: a device transfer beats a clearing rFI.
    always_comb begin
        inpr_d = inpr_q;
        fgi_d  = fgi_q;
        if (in_xfer) begin
            inpr_d = dev_in_data;
            fgi_d  = 1'b1;
        end else if (rFI) begin
            fgi_d  = 1'b0;
        end
    end

    // Output buffer: sFO over rFO over handshake completion.
    always_comb begin
        outr_d  = outr_q;
        fgo_d   = fgo_q;
        odone_d = odone_q;
        if (out_wr) begin
            outr_d = out_data;
        end
        if (sFO) begin
            fgo_d   = 1'b1;
            odone_d = 1'b0;
        end else if (rFO) begin
            fgo_d   = 1'b0;
            odone_d = 1'b0;
        end else if (out_done) begin
            fgo_d   = 1'b0;
            odone_d = 1'b1;
        end
    end

    // Interrupt enable: IOF wins over ION; an accepted acknowledge disables.
    always_comb begin
        ien_d = ien_q;
        if (IOF) begin
            ien_d = 1'b0;
        end else if (ION) begin
            ien_d = 1'b1;
        end else if (ack_accept) begin
            ien_d = 1'b0;
        end
    end

    // Interrupt FSM next state; irq is the registered REQ indication.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (src) begin
                    state_d = ST_REQ;
                end
            end
            ST_REQ: begin
                if (IOF) begin
                    state_d = ST_IDLE;
                end else if (irq_ack) begin
                    state_d = ST_SVC;
                end else if (!src) begin
                    state_d = ST_IDLE;
                end
            end
            ST_SVC: begin
                if (ION) begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
        irq_d = (state_d == ST_REQ);
    end

    // State registers; IEN resets to 1 to match the controller's reset ION.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            inpr_q  <= '0;
            outr_q  <= '0;
            fgi_q   <= 1'b0;
            fgo_q   <= 1'b0;
            odone_q <= 1'b0;
            ien_q   <= 1'b1;
            irq_q   <= 1'b0;
            state_q <= ST_IDLE;
        end else begin
            inpr_q  <= inpr_d;
            outr_q  <= outr_d;
            fgi_q   <= fgi_d;
            fgo_q   <= fgo_d;
            odone_q <= odone_d;
            ien_q   <= ien_d;
            irq_q   <= irq_d;
            state_q <= state_d;
        end
    end

    assign in_data       = inpr_q;
    assign dev_out_data  = outr_q;
    assign dev_in_ready  = ~fgi_q;
    assign dev_out_valid = fgo_q;
    assign irq           = irq_q;
    assign FGI           = fgi_q;
    assign FGO           = fgo_q;
    assign IEN           = ien_q;

endmodule
`default_nettype wire

// File: tb/tb_io_flag_unit.sv
`default_nettype none
// ============================================================================
// Module   : tb_io_flag_unit
// Brief    : Self-checking bench for io_flag_unit. A behavioural model pushes
//            the expected output snapshot for every clock edge into a queue;
//            a monitor pops and compares after each edge. Directed sequences
//            are followed by a randomized phase.
// Revision : 1.0 - initial release
// ============================================================================
module tb_io_flag_unit;

    localparam int DW = 16;
    localparam int PW = 2 * DW + 6;

    logic          clk = 1'b0;
    logic          reset_n;
    logic          rFI, sFO, rFO, ION, IOF, out_wr;
    logic [DW-1:0] out_data;
    logic [DW-1:0] in_data;
    logic          dev_in_valid;
    logic [DW-1:0] dev_in_data;
    logic          dev_in_ready;
    logic          dev_out_valid;
    logic [DW-1:0] dev_out_data;
    logic          dev_out_ready;
    logic          irq, irq_ack;
    logic          FGI, FGO, IEN;

    int n_checks = 0;
    int n_err    = 0;

    io_flag_unit #(.DATA_W(DW)) dut (
        .clk           (clk),
        .reset_n       (reset_n),
        .rFI           (rFI),
        .sFO           (sFO),
        .rFO           (rFO),
        .ION           (ION),
        .IOF           (IOF),
        .out_wr        (out_wr),
        .out_data      (out_data),
        .in_data       (in_data),
        .dev_in_valid  (dev_in_valid),
        .dev_in_data   (dev_in_data),
        .dev_in_ready  (dev_in_ready),
        .dev_out_valid (dev_out_valid),
        .dev_out_data  (dev_out_data),
        .dev_out_ready (dev_out_ready),
        .irq           (irq),
        .irq_ack       (irq_ack),
        .FGI           (FGI),
        .FGO           (FGO),
        .IEN           (IEN)
    );

    always #5 clk = ~clk;

    // ---------------- behavioural reference model ----------------
    bit          m_fgi, m_fgo, m_odone, m_ien;
    bit          m_req, m_svc;           // requesting / being serviced
    bit [DW-1:0] m_inpr, m_outr;
    logic [PW-1:0] exp_q[$];

    task automatic model_reset();
        m_fgi = 0; m_fgo = 0; m_odone = 0; m_ien = 1;
        m_req = 0; m_svc = 0;
        m_inpr = '0; m_outr = '0;
        exp_q.delete();
    endtask

    task automatic model_step();
        bit pending, took_word, delivered, ack_taken;
        bit n_fgi, n_fgo, n_odone, n_ien, n_req, n_svc;
        pending   = m_ien && (m_fgi || m_odone);
        took_word = dev_in_valid && !m_fgi;
        delivered = m_fgo && dev_out_ready;
        ack_taken = m_req && irq_ack && !IOF;
        // buffers and flags
        n_fgi = took_word ? 1'b1 : (rFI ? 1'b0 : m_fgi);
        if (took_word) m_inpr = dev_in_data;
        if (out_wr)    m_outr = out_data;
        n_fgo = m_fgo; n_odone = m_odone;
        if (sFO)            begin n_fgo = 1; n_odone = 0; end
        else if (rFO)       begin n_fgo = 0; n_odone = 0; end
        else if (delivered) begin n_fgo = 0; n_odone = 1; end
        if (IOF)            n_ien = 0;
        else if (ION)       n_ien = 1;
        else if (ack_taken) n_ien = 0;
        else                n_ien = m_ien;
        // request lifecycle
        n_req = m_req; n_svc = m_svc;
        if (m_svc) begin
            if (ION) n_svc = 0;
        end else if (m_req) begin
            if (IOF)               n_req = 0;
            else if (irq_ack)      begin n_req = 0; n_svc = 1; end
            else if (!pending)     n_req = 0;
        end else if (pending) begin
            n_req = 1;
        end
        m_fgi = n_fgi; m_fgo = n_fgo; m_odone = n_odone; m_ien = n_ien;
        m_req = n_req; m_svc = n_svc;
        exp_q.push_back({m_req, m_fgi, m_fgo, m_ien, ~m_fgi, m_fgo, m_outr, m_inpr});
    endtask

    initial begin
        model_reset();
        forever begin
            @(posedge clk or negedge reset_n);
            if (!reset_n) model_reset();
            else          model_step();
        end
    end

    // ---------------- checking ----------------
    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Monitor: compare the DUT snapshot after every edge against the model.
    initial begin
        logic [PW-1:0] e, a;
        forever begin
            @(posedge clk);
            #1;
            if (reset_n && exp_q.size() > 0) begin
                e = exp_q.pop_front();
                a = {irq, FGI, FGO, IEN, dev_in_ready, dev_out_valid, dev_out_data, in_data};
                chk("snapshot {irq,FGI,FGO,IEN,rdy,vld,dout,din}", 64'(a), 64'(e));
            end
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    // ---------------- stimulus ----------------
    task automatic clr();
        rFI = 0; sFO = 0; rFO = 0; ION = 0; IOF = 0; out_wr = 0;
        out_data = '0; dev_in_valid = 0; dev_in_data = '0;
        dev_out_ready = 0; irq_ack = 0;
    endtask

    // Advance to the next falling edge and idle all inputs.
    task automatic cyc();
        @(negedge clk);
        clr();
    endtask

    initial begin
        clr();
        reset_n = 0;
        repeat (2) @(negedge clk);
        reset_n = 1;
        chk("reset irq", 64'(irq), 64'd0);
        chk("reset IEN", 64'(IEN), 64'd1);
        chk("reset dev_in_ready", 64'(dev_in_ready), 64'd1);
        chk("reset dev_out_valid", 64'(dev_out_valid), 64'd0);

        // Input path with interrupt service
        dev_in_valid = 1; dev_in_data = 16'hA5C3;
        cyc();
        chk("in FGI", 64'(FGI), 64'd1);
        chk("in data", 64'(in_data), 64'hA5C3);
        chk("in ready low", 64'(dev_in_ready), 64'd0);
        chk("in irq not yet", 64'(irq), 64'd0);
        cyc();
        chk("in irq", 64'(irq), 64'd1);
        irq_ack = 1;
        cyc();
        chk("ack irq", 64'(irq), 64'd0);
        chk("ack IEN", 64'(IEN), 64'd0);
        rFI = 1;
        cyc();
        chk("rFI FGI", 64'(FGI), 64'd0);
        ION = 1;
        cyc();
        chk("ION IEN", 64'(IEN), 64'd1);
        cyc();
        chk("idle after ION irq", 64'(irq), 64'd0);

        // Output path with back-pressure
        out_wr = 1; out_data = 16'h1234;
        cyc();
        sFO = 1;
        cyc();
        chk("out valid", 64'(dev_out_valid), 64'd1);
        chk("out data", 64'(dev_out_data), 64'h1234);
        for (int i = 0; i < 3; i++) begin
            cyc();
            chk("out valid held", 64'(dev_out_valid), 64'd1);
        end
        dev_out_ready = 1;
        cyc();
        chk("out done FGO", 64'(FGO), 64'd0);
        chk("out done irq not yet", 64'(irq), 64'd0);
        cyc();
        chk("out done irq", 64'(irq), 64'd1);
        irq_ack = 1;
        cyc();
        rFO = 1;
        cyc();
        ION = 1;
        cyc();
        cyc();
        chk("out serviced irq", 64'(irq), 64'd0);
        chk("out serviced IEN", 64'(IEN), 64'd1);

        // Same-cycle priorities
        sFO = 1;
        cyc();
        sFO = 1; dev_out_ready = 1;
        cyc();
        chk("sFO beats completion FGO", 64'(FGO), 64'd1);
        cyc();
        chk("sFO beats completion no irq", 64'(irq), 64'd0);
        rFO = 1;
        cyc();
        chk("rFO FGO", 64'(FGO), 64'd0);
        IOF = 1; ION = 1;
        cyc();
        chk("IOF beats ION", 64'(IEN), 64'd0);
        ION = 1;
        cyc();
        chk("ION restores IEN", 64'(IEN), 64'd1);

        // Request withdrawal
        dev_in_valid = 1; dev_in_data = 16'h0F0F;
        cyc();
        cyc();
        chk("withdraw irq up", 64'(irq), 64'd1);
        IOF = 1;
        cyc();
        chk("IOF drops irq", 64'(irq), 64'd0);
        chk("IOF clears IEN", 64'(IEN), 64'd0);
        ION = 1;
        cyc();
        cyc();
        chk("re-request irq", 64'(irq), 64'd1);
        rFI = 1;
        cyc();
        cyc();
        chk("rFI withdraws irq", 64'(irq), 64'd0);

        // Input back-pressure
        dev_in_valid = 1; dev_in_data = 16'h1111;
        cyc();
        chk("bp first word", 64'(in_data), 64'h1111);
        for (int i = 0; i < 5; i++) begin
            dev_in_valid = 1; dev_in_data = 16'h2222;
            cyc();
            chk("bp INPR held", 64'(in_data), 64'h1111);
        end
        rFI = 1; dev_in_valid = 1; dev_in_data = 16'h2222;
        cyc();
        chk("bp rFI clears FGI", 64'(FGI), 64'd0);
        dev_in_valid = 1; dev_in_data = 16'h2222;
        cyc();
        chk("bp next word", 64'(in_data), 64'h2222);
        chk("bp next FGI", 64'(FGI), 64'd1);

        // Asynchronous reset with FGO=1 and irq=1
        sFO = 1;
        cyc();
        cyc();
        cyc();
        chk("pre-reset irq", 64'(irq), 64'd1);
        chk("pre-reset FGO", 64'(FGO), 64'd1);
        #2;
        reset_n = 0;
        #1;
        chk("async irq", 64'(irq), 64'd0);
        chk("async FGI", 64'(FGI), 64'd0);
        chk("async FGO", 64'(FGO), 64'd0);
        chk("async IEN", 64'(IEN), 64'd1);
        chk("async ready", 64'(dev_in_ready), 64'd1);
        chk("async valid", 64'(dev_out_valid), 64'd0);
        chk("async in_data", 64'(in_data), 64'd0);
        chk("async out_data", 64'(dev_out_data), 64'd0);
        repeat (2) @(negedge clk);
        reset_n = 1;

        // Randomized phase
        for (int n = 0; n < 3000; n++) begin
            cyc();
            dev_in_valid  = ($urandom_range(0, 99) < 50);
            dev_in_data   = 16'($urandom);
            rFI           = ($urandom_range(0, 99) < 20);
            sFO           = ($urandom_range(0, 99) < 15);
            rFO           = ($urandom_range(0, 99) < 5);
            out_wr        = ($urandom_range(0, 99) < 20);
            out_data      = 16'($urandom);
            dev_out_ready = ($urandom_range(0, 99) < 40);
            irq_ack       = m_req ? ($urandom_range(0, 99) < 40) : ($urandom_range(0, 99) < 5);
            ION           = !irq_ack && ($urandom_range(0, 99) < 10);
            IOF           = ($urandom_range(0, 99) < 4);
        end
        repeat (3) cyc();
        chk("scoreboard drained", 64'(exp_q.size()), 64'd0);

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
